// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx_top: serial input, line clear, byte and line results.
// The receiver takes the slave modport and the consuming logic takes the master modport.
interface uart_rx_if #(
    parameter int CHAR_NR = 8
);
    logic                 rxd_i;
    logic                 clr_i;
    logic [7:0]           rx_data_o;
    logic                 rx_valid_o;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic [CHAR_NR*8-1:0] char_array_o;
    logic                 char_array_update_o;
    logic                 busy_o;

    modport slave (
        input  rxd_i, clr_i,
        output rx_data_o, rx_valid_o, frame_err_o, parity_err_o,
               char_array_o, char_array_update_o, busy_o
    );

    modport master (
        output rxd_i, clr_i,
        input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o,
               char_array_o, char_array_update_o, busy_o
    );
endinterface

// File: rtl/uart_rx_top.sv
// UART receiver (8N1, LSB first) that packs received bytes into a CHAR_NR-character line.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_top #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CHAR_NR      = 8
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave rx
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
    localparam int LINE_W = CHAR_NR * 8;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_NR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [CNT_W-1:0]    baudCnt_q, baudCnt_d;
    logic [2:0]          bitCnt_q, bitCnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          rxData_q, rxData_d;
    logic                rxValid_q, rxValid_d;
    logic                frameErr_q, frameErr_d;
    logic [LINE_W-1:0]   lineBuf_q, lineBuf_d;
    logic [IDX_W-1:0]    wrIdx_q, wrIdx_d;
    logic [LINE_W-1:0]   charArray_q, charArray_d;
    logic                charUpd_q, charUpd_d;
    logic                byteOk;
    logic                rxd;
    logic                tick;
`ifdef UART_RX_PARITY_EN
    logic                parityBad_q, parityBad_d;
    logic                parityErr_q, parityErr_d;
`endif

    assign rxd  = sync2_q;
    assign tick = (baudCnt_q == '0);

    // Receive FSM: IDLE is only entered with the line high, so a low level there is a falling edge.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = tick ? baudCnt_q : baudCnt_q - CNT_W'(1);
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        frameErr_d = 1'b0;
        byteOk     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d = parityBad_q;
        parityErr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bitCnt_d = 3'd0;
                if (!rxd) begin
                    state_d   = START;
                    baudCnt_d = HALF_BIT;
                end
            end
            START: begin
                if (tick) begin
                    baudCnt_d = FULL_BIT;
                    state_d   = rxd ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rxd, shift_q[7:1]};
                    baudCnt_d = FULL_BIT;
                    bitCnt_d  = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    parityBad_d = ^{shift_q, rxd};
                    baudCnt_d   = FULL_BIT;
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (!rxd) begin
                        frameErr_d = 1'b1;
                        state_d    = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (parityBad_q) begin
                        parityErr_d = 1'b1;
`endif
                    end else begin
                        byteOk    = 1'b1;
                        rxValid_d = 1'b1;
                        rxData_d  = shift_q;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line packing: CR terminates without being stored; a full line publishes on its last slot.
    always_comb begin
        lineBuf_d   = lineBuf_q;
        wrIdx_d     = wrIdx_q;
        charArray_d = charArray_q;
        charUpd_d   = 1'b0;
        if (rx.clr_i) begin
            lineBuf_d = '0;
            wrIdx_d   = '0;
        end else if (byteOk) begin
            if (shift_q == 8'h0D) begin
                charArray_d = lineBuf_q;
                charUpd_d   = 1'b1;
                lineBuf_d   = '0;
                wrIdx_d     = '0;
            end else begin
                lineBuf_d[{wrIdx_q, 3'b000} +: 8] = shift_q;
                if (wrIdx_q == LAST_IDX) begin
                    charArray_d = lineBuf_d;
                    charUpd_d   = 1'b1;
                    lineBuf_d   = '0;
                    wrIdx_d     = '0;
                end else begin
                    wrIdx_d = wrIdx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            rxData_q    <= 8'h00;
            rxValid_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            lineBuf_q   <= '0;
            wrIdx_q     <= '0;
            charArray_q <= '0;
            charUpd_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx.rxd_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            frameErr_q  <= frameErr_d;
            lineBuf_q   <= lineBuf_d;
            wrIdx_q     <= wrIdx_d;
            charArray_q <= charArray_d;
            charUpd_q   <= charUpd_d;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= parityBad_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    assign rx.rx_data_o           = rxData_q;
    assign rx.rx_valid_o          = rxValid_q;
    assign rx.frame_err_o         = frameErr_q;
    assign rx.char_array_o        = charArray_q;
    assign rx.char_array_update_o = charUpd_q;
    assign rx.busy_o              = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err_o        = parityErr_q;
`else
    assign rx.parity_err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_top.sv
// Directed self-checking bench for uart_rx_top at CLKS_PER_BIT=16, CHAR_NR=8.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity checks.
module tb_uart_rx_top;
    localparam int CPB = 16;
    localparam int CHARS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if #(.CHAR_NR(CHARS)) rxIf ();

    uart_rx_top #(
        .CLKS_PER_BIT(CPB),
        .CHAR_NR     (CHARS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rxIf.slave)
    );

    always #5 clk = ~clk;

    int vecCnt = 0;
    int errCnt = 0;
    int validCycles = 0;
    int frameCycles = 0;
    int parityCycles = 0;
    int updCycles = 0;
`ifdef UART_RX_PARITY_EN
    logic parityFlip = 1'b0;
`endif

    // Pulse outputs are counted in high cycles, so a delta of 1 also proves a single-cycle pulse.
    always @(negedge clk) begin
        if (rxIf.rx_valid_o)          validCycles++;
        if (rxIf.frame_err_o)         frameCycles++;
        if (rxIf.parity_err_o)        parityCycles++;
        if (rxIf.char_array_update_o) updCycles++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vecCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One full frame on rxd_i, followed by a few idle-high cycles.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rxIf.rxd_i = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxIf.rxd_i = data[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxIf.rxd_i = (^data) ^ parityFlip;
        repeat (CPB) @(posedge clk);
`endif
        rxIf.rxd_i = stopBit;
        repeat (CPB) @(posedge clk);
        rxIf.rxd_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        rxIf.clr_i = 1'b1;
        @(posedge clk);
        #1;
        rxIf.clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int v0, f0, p0, u0;
        string s;
        rxIf.rxd_i = 1'b1;
        rxIf.clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rx_data", {56'h0, rxIf.rx_data_o}, 64'h0);
        checkOutput("reset rx_valid", {63'h0, rxIf.rx_valid_o}, 64'h0);
        checkOutput("reset char_array", rxIf.char_array_o, 64'h0);
        checkOutput("reset busy", {63'h0, rxIf.busy_o}, 64'h0);
        checkOutput("reset frame_err", {63'h0, rxIf.frame_err_o}, 64'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single good byte
        v0 = validCycles; f0 = frameCycles; p0 = parityCycles; u0 = updCycles;
        applyStimulus(8'h41, 1'b1);
        checkOutput("0x41 valid pulses", 64'(validCycles - v0), 64'd1);
        checkOutput("0x41 data", {56'h0, rxIf.rx_data_o}, 64'h41);
        checkOutput("0x41 frame_err", 64'(frameCycles - f0), 64'd0);
        checkOutput("0x41 parity_err", 64'(parityCycles - p0), 64'd0);
        checkOutput("0x41 no update", 64'(updCycles - u0), 64'd0);
        checkOutput("0x41 busy after", {63'h0, rxIf.busy_o}, 64'h0);

        // False start
        v0 = validCycles; f0 = frameCycles; u0 = updCycles;
        rxIf.rxd_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("false start busy", {63'h0, rxIf.busy_o}, 64'h1);
        rxIf.rxd_i = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("false start busy end", {63'h0, rxIf.busy_o}, 64'h0);
        checkOutput("false start valid", 64'(validCycles - v0), 64'd0);
        checkOutput("false start frame", 64'(frameCycles - f0), 64'd0);

        // Framing error
        v0 = validCycles; f0 = frameCycles;
        applyStimulus(8'h55, 1'b0);
        checkOutput("ferr frame pulses", 64'(frameCycles - f0), 64'd1);
        checkOutput("ferr valid", 64'(validCycles - v0), 64'd0);
        checkOutput("ferr data held", {56'h0, rxIf.rx_data_o}, 64'h41);
        checkOutput("ferr busy after", {63'h0, rxIf.busy_o}, 64'h0);

        // Full 8-character line (buffer holds 'A' from earlier, so clear first)
        pulseClear();
        v0 = validCycles; u0 = updCycles;
        s = "12345678";
        for (int i = 0; i < 8; i++) applyStimulus(s[i], 1'b1);
        checkOutput("full line updates", 64'(updCycles - u0), 64'd1);
        checkOutput("full line valids", 64'(validCycles - v0), 64'd8);
        checkOutput("full line array", rxIf.char_array_o, 64'h3837363534333231);
        checkOutput("full line last byte", {56'h0, rxIf.rx_data_o}, 64'h38);

        // CR-terminated short line
        u0 = updCycles;
        s = "1.5";
        for (int i = 0; i < 3; i++) applyStimulus(s[i], 1'b1);
        checkOutput("short line no early upd", 64'(updCycles - u0), 64'd0);
        applyStimulus(8'h0D, 1'b1);
        checkOutput("short line updates", 64'(updCycles - u0), 64'd1);
        checkOutput("short line array", rxIf.char_array_o, 64'h0000000000352E31);

        // Clear discards the pending "9"; CR at index 0 publishes an empty line
        u0 = updCycles;
        applyStimulus(8'h39, 1'b1);
        pulseClear();
        checkOutput("clr keeps array", rxIf.char_array_o, 64'h0000000000352E31);
        applyStimulus(8'h0D, 1'b1);
        checkOutput("empty line updates", 64'(updCycles - u0), 64'd1);
        checkOutput("empty line array", rxIf.char_array_o, 64'h0);

`ifdef UART_RX_PARITY_EN
        v0 = validCycles; p0 = parityCycles;
        parityFlip = 1'b1;
        applyStimulus(8'h03, 1'b1);
        parityFlip = 1'b0;
        checkOutput("bad parity pulses", 64'(parityCycles - p0), 64'd1);
        checkOutput("bad parity valid", 64'(validCycles - v0), 64'd0);
        v0 = validCycles; p0 = parityCycles;
        applyStimulus(8'h03, 1'b1);
        checkOutput("good parity valid", 64'(validCycles - v0), 64'd1);
        checkOutput("good parity data", {56'h0, rxIf.rx_data_o}, 64'h03);
        checkOutput("good parity no err", 64'(parityCycles - p0), 64'd0);
`endif

        // Async reset in the middle of a frame
        rxIf.rxd_i = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("midframe busy", {63'h0, rxIf.busy_o}, 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", {63'h0, rxIf.busy_o}, 64'h0);
        checkOutput("midreset data", {56'h0, rxIf.rx_data_o}, 64'h0);
        checkOutput("midreset array", rxIf.char_array_o, 64'h0);
        rxIf.rxd_i = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Recovery after reset
        v0 = validCycles;
        applyStimulus(8'h5A, 1'b1);
        checkOutput("recover valid", 64'(validCycles - v0), 64'd1);
        checkOutput("recover data", {56'h0, rxIf.rx_data_o}, 64'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
